// File: rtl/req_queue4.sv
// Four-channel request staging buffer feeding a 4-input grant arbiter.
// Each channel is an independent small FIFO; the head entry is popped by its grant pulse.
module req_queue4 #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          wr_en0,
    input  logic          wr_en1,
    input  logic          wr_en2,
    input  logic          wr_en3,
    input  logic [DW-1:0] wr_data0,
    input  logic [DW-1:0] wr_data1,
    input  logic [DW-1:0] wr_data2,
    input  logic [DW-1:0] wr_data3,
    output logic          full0,
    output logic          full1,
    output logic          full2,
    output logic          full3,

    output logic          req0,
    output logic          req1,
    output logic          req2,
    output logic          req3,
    output logic [DW-1:0] rd_data0,
    output logic [DW-1:0] rd_data1,
    output logic [DW-1:0] rd_data2,
    output logic [DW-1:0] rd_data3,
    input  logic          gnt0,
    input  logic          gnt1,
    input  logic          gnt2,
    input  logic          gnt3,

    output logic [AW:0]   level0,
    output logic [AW:0]   level1,
    output logic [AW:0]   level2,
    output logic [AW:0]   level3,
    output logic [3:0]    ovf
);

    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [3:0]    wr_en_v;
    logic [3:0]    gnt_v;
    logic [3:0]    full_v;
    logic [3:0]    req_v;
    logic [3:0]    ovf_set;
    logic [DW-1:0] wr_data_v [4];
    logic [DW-1:0] rd_data_v [4];
    logic [AW:0]   level_v   [4];

    assign wr_en_v      = {wr_en3, wr_en2, wr_en1, wr_en0};
    assign gnt_v        = {gnt3, gnt2, gnt1, gnt0};
    assign wr_data_v[0] = wr_data0;
    assign wr_data_v[1] = wr_data1;
    assign wr_data_v[2] = wr_data2;
    assign wr_data_v[3] = wr_data3;

    assign {full3, full2, full1, full0} = full_v;
    assign {req3, req2, req1, req0}     = req_v;
    assign rd_data0 = rd_data_v[0];
    assign rd_data1 = rd_data_v[1];
    assign rd_data2 = rd_data_v[2];
    assign rd_data3 = rd_data_v[3];
    assign level0   = level_v[0];
    assign level1   = level_v[1];
    assign level2   = level_v[2];
    assign level3   = level_v[3];

    for (genvar c = 0; c < 4; c++) begin : g_ch
        logic [DW-1:0] mem [DEPTH];
        logic [AW-1:0] wptr;
        logic [AW-1:0] rptr;
        logic [AW:0]   level;
        logic          push;
        logic          pop;

        // Full/empty come from the occupancy count, so pointers may wrap freely.
        assign full_v[c]  = (level == FULL_LVL);
        assign req_v[c]   = (level != '0);
        assign push       = wr_en_v[c] && !full_v[c];
        assign pop        = gnt_v[c] && req_v[c];
        assign ovf_set[c] = wr_en_v[c] && full_v[c];
        assign level_v[c] = level;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
            end else begin
                if (push)
                    wptr <= wptr + 1'b1;
                if (pop)
                    rptr <= rptr + 1'b1;
                case ({push, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (push)
                mem[wptr] <= wr_data_v[c];
        end

        // Storage is never cleared, so mask the head while empty to present zero.
        assign rd_data_v[c] = req_v[c] ? mem[rptr] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= '0;
        else
            ovf <= ovf | ovf_set;
    end

endmodule

// File: doc/req_queue4.md
Name: req_queue4

Overview:
- Four-channel request staging buffer that sits directly upstream of the 4-input fixed-priority grant arbiter.
- Each channel has a small FIFO that absorbs bursty producer writes.
- Each channel presents a level request (reqN = FIFO not empty) and its head-of-queue payload to the arbiter.
- The head entry is popped when the arbiter returns the matching single-cycle grant pulse gntN.

Parameters:
- DW, 8: payload width per entry.
- DEPTH, 4: entries per channel FIFO; must be a power of two, at least 2.
- AW, 2: pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en0..wr_en3  in  1 each  producer write strobe, channel N.
- wr_data0..wr_data3  in  DW each  producer payload, channel N.
- full0..full3  out  1 each  channel N holds DEPTH entries.
- req0..req3  out  1 each  channel N not empty; drives arbiter reqN.
- rd_data0..rd_data3  out  DW each  head entry of channel N.
- gnt0..gnt3  in  1 each  arbiter grant pulse; pops channel N.
- level0..level3  out  AW+1 each  occupancy of channel N, range 0..DEPTH.
- ovf  out  4  sticky overflow flag per channel; bit N = channel N.

Behaviour:
- Reset (async, rst=1):
  - All write/read pointers and levels = 0; storage contents are don't-care.
  - Outputs: reqN=0, fullN=0, levelN=0, ovf=4'b0000, rd_dataN=0.
- Channels are fully independent. Identical logic is replicated 4 times; only the ovf vector is shared.
- Push: wr_enN && !fullN at a rising edge.
  - wr_dataN is written at wptr; wptr increments modulo DEPTH; level +1.
- Overflow: wr_enN && fullN.
  - Write is dropped, and ovf[N] is set to 1.
  - This holds even if a pop occurs in the same cycle; a full FIFO never accepts a write.
  - ovf[N] clears only on reset.
- Pop: gntN && reqN at a rising edge.
  - rptr increments modulo DEPTH; level -1.
- Grant while empty (gntN && !reqN): ignored, no state change.
- Simultaneous push and pop, channel not full and not empty: both occur; level unchanged; pointers each advance.
- Simultaneous push and pop, channel empty: pop ignored, push accepted; level becomes 1.
- Output timing:
  - reqN = (levelN != 0) and fullN = (levelN == DEPTH), both decoded from registered level only.
  - rd_dataN = mem[rptr]; it changes only in the cycle after a pop or the first push into an empty FIFO.
  - Write-to-request latency: a push at edge k gives reqN=1 and valid rd_dataN from edge k onward, i.e. visible in cycle k+1.
- Arbiter contract:
  - The arbiter samples reqN combinationally and returns gntN one cycle later, high for exactly one cycle.
  - reqN and rd_dataN therefore stay stable from the sampling cycle through the grant cycle.
  - The pop happens at the end of the grant cycle, so the consumer captures rd_dataN while gntN=1.
  - The arbiter's two-cycle decision spacing guarantees at most one pop per channel per two cycles. This block does not rely on that guarantee: it accepts back-to-back grants.
- Multiple simultaneous gnt lines are legal in this block: each pops its own channel.
- Pointer wrap: pointers are AW bits and wrap DEPTH-1 -> 0 silently. Full/empty come from level, not pointer compare.
- Reset asserted mid-operation: all queued entries are discarded immediately (async); req and full drop without waiting for a clock.

Test Plan:
- Reset: hold rst=1 with random wr_en/gnt -> all reqN=0, fullN=0, levelN=0, ovf=0. Release; no spurious req.
- Single write and pop, channel 2: write 8'hA5 -> req2=1 and rd_data2=8'hA5 in the next cycle. Pulse gnt2 one cycle -> req2=0, level2=0 after that edge.
- Fill and overflow, channel 0: write 0x01..0x04 -> full0=1, level0=4. Fifth write 0x05 -> dropped, ovf[0]=1. Pop 4 times -> outputs 0x01,0x02,0x03,0x04 in order; ovf[0] stays 1.
- Wrap, channel 1: 10 writes interleaved with pops, level kept at or below 2 -> data order preserved across the pointer wrap. Simultaneous push+pop at level 1 keeps level1=1 with the new head correct.
- Edge cases, channel 3: gnt3 while empty -> no change, level3=0. Simultaneous wr_en3+gnt3 while empty -> level3=1, entry retained.
- Integration with arbiter: preload ch0={0x10,0x11}, ch3={0x30}. Run the arbiter -> grants gnt0, gnt0, gnt3, spaced two cycles apart; consumer captures 0x10, 0x11, 0x30. Assert rst mid-sequence -> all req drop asynchronously.
